cmd_pkg_rx_shk: RTL and testbench

//  Parametrised command-packet receiver on the byte shake bus from the UART bridge.

---
 rtl/cmd_pkg_rx_pkg.sv | 32 +++
 rtl/cmd_byte_pack.sv | 61 ++++++
 rtl/cmd_pkg_rx_shk.sv | 195 +++++++++++++++++++
 tb/tb_cmd_pkg_rx_shk.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_pkg_rx_pkg.sv
// Shared definitions for the command-packet receiver: FSM states, error codes
// and the status word layout.
package cmd_pkg_rx_pkg;

  typedef enum logic [2:0] {
    ST_HUNT   = 3'd0,
    ST_LEN    = 3'd1,
    ST_DATA   = 3'd2,
    ST_CHK    = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

  localparam logic [7:0] ERR_OK  = 8'd0;
  localparam logic [7:0] ERR_LEN = 8'd1;
  localparam logic [7:0] ERR_XOR = 8'd2;
  localparam logic [7:0] ERR_TMO = 8'd3;

  localparam int STS_ERR_LSB = 24;
  localparam int STS_OVF_BIT = 23;
  localparam int STS_NW_LSB  = 0;

  function automatic logic [31:0] sts_word(input logic [7:0] err, input logic ovf,
                                           input logic [15:0] nwords);
    logic [31:0] w;
    w = '0;
    w[STS_ERR_LSB +: 8]  = err;
    w[STS_OVF_BIT]       = ovf;
    w[STS_NW_LSB +: 16]  = nwords;
    return w;
  endfunction

endpackage

// File: rtl/cmd_byte_pack.sv
// Edge detector on the byte-shake ready line plus a sliding byte-to-word
// assembler; the first byte of a word ends up in the least significant lane.
module cmd_byte_pack #(
  parameter int WD_CMD_DATA = 32,
  parameter int WD_SHK_DATA = 8
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_resetn,
  input  logic                   shk_ready,
  input  logic [WD_SHK_DATA-1:0] shk_sdata,
  input  logic                   clr,
  output logic [WD_CMD_DATA-1:0] word,
  output logic                   word_vld,
  output logic                   byte_vld
);

  localparam int NBW = WD_CMD_DATA / WD_SHK_DATA;
  localparam int CW  = (NBW > 1) ? $clog2(NBW) : 1;

  logic                   rdy_reg;
  logic                   acc;
  logic                   cnt_last;
  logic [WD_CMD_DATA-1:0] word_reg;
  logic [CW-1:0]          cnt_reg;
  logic                   word_vld_reg;
  logic                   byte_vld_reg;

  assign acc      = shk_ready & ~rdy_reg;
  assign cnt_last = (cnt_reg == CW'(NBW - 1));

  // The ready history is never cleared so an edge seen during a clear is not re-detected.
  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) begin
      rdy_reg      <= 1'b0;
      word_reg     <= '0;
      cnt_reg      <= '0;
      word_vld_reg <= 1'b0;
      byte_vld_reg <= 1'b0;
    end else begin
      rdy_reg <= shk_ready;
      if (clr) begin
        word_reg     <= '0;
        cnt_reg      <= '0;
        word_vld_reg <= 1'b0;
        byte_vld_reg <= 1'b0;
      end else begin
        byte_vld_reg <= acc;
        word_vld_reg <= acc & cnt_last;
        if (acc) begin
          word_reg <= {shk_sdata, word_reg[WD_CMD_DATA-1:WD_SHK_DATA]};
          cnt_reg  <= cnt_last ? '0 : cnt_reg + CW'(1);
        end
      end
    end
  end

  assign word     = word_reg;
  assign word_vld = word_vld_reg;
  assign byte_vld = byte_vld_reg;

endmodule

// File: rtl/cmd_pkg_rx_shk.sv
// Command-packet receiver: START, LEN, payload, XOR -> atomic commit plus a status word.
// Define CMD_PKG_RX_XOR_CHK_EN to enforce the checksum; otherwise it is consumed and ignored.
module cmd_pkg_rx_shk
  import cmd_pkg_rx_pkg::*;
#(
  parameter logic [31:0] MD_CMD_START  = 32'h1331_0001,
  parameter int          NB_CMD_ORDE   = 128,
  parameter int          WD_CMD_DATA   = 32,
  parameter int          WD_SHK_DATA   = 8,
  parameter int          WD_SLEEP_SPAN = 20,
  parameter int          WD_ERR_INFO   = 4
) (
  input  logic                               i_sys_clk,
  input  logic                               i_sys_resetn,
  output logic                               m_shk_rd_valid,
  input  logic                               m_shk_rd_ready,
  input  logic [WD_SHK_DATA-1:0]             m_shk_rd_sdata,
  output logic [WD_CMD_DATA*NB_CMD_ORDE-1:0] m_cmd_dst_arry,
  output logic                               m_cmd_dst_updt,
  output logic                               m_sts_valid,
  output logic [31:0]                        m_sts_data,
  input  logic                               m_sts_ready,
  output logic [WD_ERR_INFO-1:0]             m_err_cmd_info1
);

  localparam int LW = $clog2(NB_CMD_ORDE + 1);
  localparam int IW = (NB_CMD_ORDE > 1) ? $clog2(NB_CMD_ORDE) : 1;
  localparam logic [WD_SLEEP_SPAN-1:0] IDLE_LAST = {1'b0, {(WD_SLEEP_SPAN-1){1'b1}}};

  state_t                   state_reg, state_next;
  logic [WD_CMD_DATA-1:0]   word;
  logic                     word_vld, byte_vld;
  logic                     pack_clr, data_wr, len_ld, commit_go, commit_ok;
  logic                     res_load;
  logic [7:0]               res_err;
  logic [15:0]              res_nwords;
  logic                     len_bad, idx_last, tmo;
  logic [LW-1:0]            len_reg;
  logic [IW-1:0]            idx_reg;
  logic [WD_SLEEP_SPAN-1:0] idle_reg;
  logic                     shk_valid_reg, sts_valid_reg;
  logic [31:0]              sts_data_reg;
  logic [WD_ERR_INFO-1:0]   err_reg;

  cmd_byte_pack #(
    .WD_CMD_DATA (WD_CMD_DATA),
    .WD_SHK_DATA (WD_SHK_DATA)
  ) u_pack (
    .i_sys_clk    (i_sys_clk),
    .i_sys_resetn (i_sys_resetn),
    .shk_ready    (m_shk_rd_ready),
    .shk_sdata    (m_shk_rd_sdata),
    .clr          (pack_clr),
    .word         (word),
    .word_vld     (word_vld),
    .byte_vld     (byte_vld)
  );

  assign len_bad  = (word == '0) || (word > WD_CMD_DATA'(NB_CMD_ORDE));
  assign idx_last = (LW'(idx_reg) + LW'(1)) == len_reg;
  // One-shot: fires on the cycle the counter's top bit would set.
  assign tmo      = !byte_vld && (idle_reg == IDLE_LAST);

`ifdef CMD_PKG_RX_XOR_CHK_EN
  logic [WD_CMD_DATA-1:0] xor_reg;
  assign commit_ok = (word == xor_reg);
  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn)  xor_reg <= '0;
    else if (len_ld)    xor_reg <= word;
    else if (data_wr)   xor_reg <= xor_reg ^ word;
  end
`else
  assign commit_ok = 1'b1;
`endif

  always_comb begin
    state_next = state_reg;
    pack_clr   = 1'b0;
    data_wr    = 1'b0;
    len_ld     = 1'b0;
    commit_go  = 1'b0;
    res_load   = 1'b0;
    res_err    = ERR_OK;
    res_nwords = '0;
    case (state_reg)
      ST_HUNT: begin
        if (byte_vld && word == WD_CMD_DATA'(MD_CMD_START)) begin
          state_next = ST_LEN;
          pack_clr   = 1'b1;
        end
      end
      ST_LEN: begin
        if (word_vld) begin
          if (len_bad) begin
            state_next = ST_HUNT;
            pack_clr   = 1'b1;
            res_load   = 1'b1;
            res_err    = ERR_LEN;
          end else begin
            state_next = ST_DATA;
            len_ld     = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (word_vld) begin
          data_wr = 1'b1;
          if (idx_last) state_next = ST_CHK;
        end
      end
      ST_CHK: begin
        if (word_vld) begin
          pack_clr = 1'b1;
          res_load = 1'b1;
          if (commit_ok) begin
            state_next = ST_COMMIT;
            commit_go  = 1'b1;
            res_nwords = 16'(len_reg);
          end else begin
            state_next = ST_HUNT;
            res_err    = ERR_XOR;
          end
        end
      end
      ST_COMMIT: state_next = ST_HUNT;
      default:   state_next = ST_HUNT;
    endcase
    if (tmo) begin
      pack_clr = 1'b1;
      if (state_reg != ST_HUNT && state_reg != ST_COMMIT) begin
        state_next = ST_HUNT;
        res_load   = 1'b1;
        res_err    = ERR_TMO;
        res_nwords = '0;
      end
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) begin
      state_reg     <= ST_HUNT;
      len_reg       <= '0;
      idx_reg       <= '0;
      idle_reg      <= '0;
      shk_valid_reg <= 1'b0;
      sts_valid_reg <= 1'b0;
      sts_data_reg  <= '0;
      err_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      shk_valid_reg <= 1'b1;
      if (len_ld) begin
        len_reg <= word[LW-1:0];
        idx_reg <= '0;
      end else if (data_wr) begin
        idx_reg <= idx_reg + IW'(1);
      end
      if (byte_vld)                         idle_reg <= '0;
      else if (!idle_reg[WD_SLEEP_SPAN-1])  idle_reg <= idle_reg + WD_SLEEP_SPAN'(1);
      // A fresh result beats a same-cycle ready, so nothing is dropped silently.
      if (res_load) begin
        sts_data_reg  <= sts_word(res_err, sts_valid_reg, res_nwords);
        sts_valid_reg <= 1'b1;
        err_reg       <= res_err[WD_ERR_INFO-1:0];
      end else if (m_sts_ready) begin
        sts_valid_reg <= 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NB_CMD_ORDE; gi++) begin : g_word
      logic [WD_CMD_DATA-1:0] shadow_reg;
      logic [WD_CMD_DATA-1:0] arry_reg;
      always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
        if (!i_sys_resetn) begin
          shadow_reg <= '0;
          arry_reg   <= '0;
        end else begin
          if (data_wr && idx_reg == IW'(gi))       shadow_reg <= word;
          if (commit_go && LW'(gi) < len_reg)      arry_reg   <= shadow_reg;
        end
      end
      assign m_cmd_dst_arry[gi*WD_CMD_DATA +: WD_CMD_DATA] = arry_reg;
    end
  endgenerate

  assign m_shk_rd_valid  = shk_valid_reg;
  assign m_cmd_dst_updt  = (state_reg == ST_COMMIT);
  assign m_sts_valid     = sts_valid_reg;
  assign m_sts_data      = sts_data_reg;
  assign m_err_cmd_info1 = err_reg;

endmodule

// File: tb/tb_cmd_pkg_rx_shk.sv
// Directed bench for cmd_pkg_rx_shk; idle timeout shortened to 2^9 cycles.
module tb_cmd_pkg_rx_shk;

  localparam int NB = 128;
  localparam int WD = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [7:0]    sdata = 8'h00;
  logic [WD*NB-1:0] arry;
  logic          updt;
  logic          sts_valid;
  logic [31:0]   sts_data;
  logic          sts_ready = 1'b0;
  logic [3:0]    err;

  int   vec = 0;
  int   miss = 0;
  int   updt_cnt = 0;
  int   c0;
  logic upd_t1;
  logic rdy_pulse = 1'b0;

  cmd_pkg_rx_shk #(
    .MD_CMD_START  (32'h1331_0001),
    .NB_CMD_ORDE   (NB),
    .WD_CMD_DATA   (WD),
    .WD_SHK_DATA   (8),
    .WD_SLEEP_SPAN (10),
    .WD_ERR_INFO   (4)
  ) dut (
    .i_sys_clk       (clk),
    .i_sys_resetn    (rst_n),
    .m_shk_rd_valid  (rd_valid),
    .m_shk_rd_ready  (rd_ready),
    .m_shk_rd_sdata  (sdata),
    .m_cmd_dst_arry  (arry),
    .m_cmd_dst_updt  (updt),
    .m_sts_valid     (sts_valid),
    .m_sts_data      (sts_data),
    .m_sts_ready     (sts_ready),
    .m_err_cmd_info1 (err)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (updt === 1'b1) updt_cnt++;

  function automatic logic [31:0] aw(input int j);
    return arry[32*j +: 32];
  endfunction

  // Returns in cycle T+2 of the accept; updt is sampled in T+1 into upd_t1.
  task automatic send_byte(input logic [7:0] b);
    sdata = b; rd_ready = 1'b1;
    @(posedge clk); #1;
    rd_ready = 1'b0; upd_t1 = updt;
    if (rdy_pulse) sts_ready = 1'b1;
    @(posedge clk); #1;
    if (rdy_pulse) sts_ready = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_hdr(input logic [31:0] len);
    send_word(32'h1331_0001);
    send_word(len);
  endtask

  task automatic take_sts;
    sts_ready = 1'b1;
    @(posedge clk); #1;
    sts_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vec++; if (rd_valid !== 1'b0) begin miss++; $display("FAIL rst_rd_valid got %0b want 0", rd_valid); end
    vec++; if (updt !== 1'b0) begin miss++; $display("FAIL rst_updt got %0b want 0", updt); end
    vec++; if (sts_valid !== 1'b0) begin miss++; $display("FAIL rst_sts_valid got %0b want 0", sts_valid); end
    vec++; if (sts_data !== 32'h0) begin miss++; $display("FAIL rst_sts_data got %h want 0", sts_data); end
    vec++; if (err !== 4'h0) begin miss++; $display("FAIL rst_err got %0d want 0", err); end
    vec++; if (arry !== '0) begin miss++; $display("FAIL rst_arry got word0=%h want all zero", aw(0)); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vec++; if (rd_valid !== 1'b1) begin miss++; $display("FAIL rst_rd_valid_after got %0b want 1", rd_valid); end
  endtask

  task automatic test_good;
    c0 = updt_cnt;
    send_hdr(2);
    send_word(32'h1111_1111);
    send_word(32'h2222_2222);
    send_word(32'h3333_3331);
    vec++; if (upd_t1 !== 1'b0) begin miss++; $display("FAIL good_updt_t1 got %0b want 0", upd_t1); end
    vec++; if (updt !== 1'b1) begin miss++; $display("FAIL good_updt_t2 got %0b want 1", updt); end
    vec++; if (aw(0) !== 32'h1111_1111) begin miss++; $display("FAIL good_arry0 got %h want 11111111", aw(0)); end
    vec++; if (aw(1) !== 32'h2222_2222) begin miss++; $display("FAIL good_arry1 got %h want 22222222", aw(1)); end
    vec++; if (aw(2) !== 32'h0) begin miss++; $display("FAIL good_arry2 got %h want 0", aw(2)); end
    vec++; if (sts_valid !== 1'b1) begin miss++; $display("FAIL good_sts_valid got %0b want 1", sts_valid); end
    vec++; if (sts_data !== 32'h0000_0002) begin miss++; $display("FAIL good_sts got %h want 00000002", sts_data); end
    vec++; if (err !== 4'h0) begin miss++; $display("FAIL good_err got %0d want 0", err); end
    @(posedge clk); #1;
    vec++; if (updt !== 1'b0) begin miss++; $display("FAIL good_updt_t3 got %0b want 0", updt); end
    vec++; if (updt_cnt - c0 !== 1) begin miss++; $display("FAIL good_updt_len got %0d want 1", updt_cnt - c0); end
    take_sts;
    vec++; if (sts_valid !== 1'b0) begin miss++; $display("FAIL good_sts_take got %0b want 0", sts_valid); end
  endtask

  task automatic test_xor;
    send_hdr(2);
    send_word(32'hAAAA_5555);
    send_word(32'h0F0F_0F0F);
    send_word(32'h0000_0000);
`ifdef CMD_PKG_RX_XOR_CHK_EN
    vec++; if (updt !== 1'b0) begin miss++; $display("FAIL xor_updt got %0b want 0", updt); end
    vec++; if (err !== 4'h2) begin miss++; $display("FAIL xor_err got %0d want 2", err); end
    vec++; if (sts_data !== 32'h0200_0000) begin miss++; $display("FAIL xor_sts got %h want 02000000", sts_data); end
    vec++; if (aw(0) !== 32'h1111_1111) begin miss++; $display("FAIL xor_arry0 got %h want 11111111", aw(0)); end
    vec++; if (aw(1) !== 32'h2222_2222) begin miss++; $display("FAIL xor_arry1 got %h want 22222222", aw(1)); end
`else
    vec++; if (updt !== 1'b1) begin miss++; $display("FAIL xor_updt got %0b want 1", updt); end
    vec++; if (err !== 4'h0) begin miss++; $display("FAIL xor_err got %0d want 0", err); end
    vec++; if (sts_data !== 32'h0000_0002) begin miss++; $display("FAIL xor_sts got %h want 00000002", sts_data); end
    vec++; if (aw(0) !== 32'hAAAA_5555) begin miss++; $display("FAIL xor_arry0 got %h want aaaa5555", aw(0)); end
    vec++; if (aw(1) !== 32'h0F0F_0F0F) begin miss++; $display("FAIL xor_arry1 got %h want 0f0f0f0f", aw(1)); end
`endif
    vec++; if (sts_valid !== 1'b1) begin miss++; $display("FAIL xor_sts_valid got %0b want 1", sts_valid); end
    take_sts;
  endtask

  task automatic test_len_err;
    send_hdr(0);
    vec++; if (err !== 4'h1) begin miss++; $display("FAIL len0_err got %0d want 1", err); end
    vec++; if (sts_data !== 32'h0100_0000) begin miss++; $display("FAIL len0_sts got %h want 01000000", sts_data); end
    vec++; if (sts_valid !== 1'b1) begin miss++; $display("FAIL len0_sts_valid got %0b want 1", sts_valid); end
    take_sts;
    send_hdr(129);
    vec++; if (err !== 4'h1) begin miss++; $display("FAIL len129_err got %0d want 1", err); end
    vec++; if (sts_data !== 32'h0100_0000) begin miss++; $display("FAIL len129_sts got %h want 01000000", sts_data); end
    vec++; if (sts_valid !== 1'b1) begin miss++; $display("FAIL len129_sts_valid got %0b want 1", sts_valid); end
    take_sts;
    send_hdr(3);
    send_word(32'h0102_0304);
    send_word(32'hA5A5_A5A5);
    send_word(32'hDEAD_BEEF);
    send_word(32'h7A0A_184D);
    vec++; if (updt !== 1'b1) begin miss++; $display("FAIL len3_updt got %0b want 1", updt); end
    vec++; if (aw(0) !== 32'h0102_0304) begin miss++; $display("FAIL len3_arry0 got %h want 01020304", aw(0)); end
    vec++; if (aw(1) !== 32'hA5A5_A5A5) begin miss++; $display("FAIL len3_arry1 got %h want a5a5a5a5", aw(1)); end
    vec++; if (aw(2) !== 32'hDEAD_BEEF) begin miss++; $display("FAIL len3_arry2 got %h want deadbeef", aw(2)); end
    vec++; if (aw(3) !== 32'h0) begin miss++; $display("FAIL len3_arry3 got %h want 0", aw(3)); end
    vec++; if (sts_data !== 32'h0000_0003) begin miss++; $display("FAIL len3_sts got %h want 00000003", sts_data); end
    take_sts;
  endtask

  task automatic test_timeout;
    c0 = updt_cnt;
    send_hdr(2);
    send_byte(8'h99);
    send_byte(8'h88);
    send_byte(8'h77);
    repeat (530) @(posedge clk);
    #1;
    vec++; if (err !== 4'h3) begin miss++; $display("FAIL tmo_err got %0d want 3", err); end
    vec++; if (sts_data !== 32'h0300_0000) begin miss++; $display("FAIL tmo_sts got %h want 03000000", sts_data); end
    vec++; if (sts_valid !== 1'b1) begin miss++; $display("FAIL tmo_sts_valid got %0b want 1", sts_valid); end
    vec++; if (aw(0) !== 32'h0102_0304) begin miss++; $display("FAIL tmo_arry0 got %h want 01020304", aw(0)); end
    vec++; if (updt_cnt !== c0) begin miss++; $display("FAIL tmo_no_updt got %0d want %0d", updt_cnt, c0); end
    take_sts;
    send_hdr(1);
    send_word(32'h5A5A_5A5A);
    send_word(32'h5A5A_5A5B);
    vec++; if (updt !== 1'b1) begin miss++; $display("FAIL tmo_next_updt got %0b want 1", updt); end
    vec++; if (aw(0) !== 32'h5A5A_5A5A) begin miss++; $display("FAIL tmo_next_arry0 got %h want 5a5a5a5a", aw(0)); end
    vec++; if (aw(1) !== 32'hA5A5_A5A5) begin miss++; $display("FAIL tmo_next_arry1 got %h want a5a5a5a5", aw(1)); end
    vec++; if (sts_data !== 32'h0000_0001) begin miss++; $display("FAIL tmo_next_sts got %h want 00000001", sts_data); end
    take_sts;
  endtask

  task automatic test_ovf;
    send_hdr(1);
    send_word(32'h0000_0011);
    send_word(32'h0000_0010);
    vec++; if (sts_data !== 32'h0000_0001) begin miss++; $display("FAIL ovf_first_sts got %h want 00000001", sts_data); end
    send_hdr(2);
    send_word(32'h0000_0001);
    send_word(32'h0000_0002);
    send_word(32'h0000_0001);
    vec++; if (sts_data !== 32'h0080_0002) begin miss++; $display("FAIL ovf_second_sts got %h want 00800002", sts_data); end
    send_hdr(1);
    send_word(32'h0000_0003);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h00);
    rdy_pulse = 1'b1;
    send_byte(8'h00);
    rdy_pulse = 1'b0;
    vec++; if (sts_valid !== 1'b1) begin miss++; $display("FAIL ovf_race_valid got %0b want 1", sts_valid); end
    vec++; if (sts_data[15:0] !== 16'h0001) begin miss++; $display("FAIL ovf_race_nwords got %h want 0001", sts_data[15:0]); end
    vec++; if (aw(0) !== 32'h0000_0003) begin miss++; $display("FAIL ovf_race_arry0 got %h want 00000003", aw(0)); end
    @(posedge clk); #1;
    vec++; if (sts_valid !== 1'b1) begin miss++; $display("FAIL ovf_race_hold got %0b want 1", sts_valid); end
    take_sts;
    vec++; if (sts_valid !== 1'b0) begin miss++; $display("FAIL ovf_take got %0b want 0", sts_valid); end
  endtask

  task automatic test_reset_mid;
    send_hdr(2);
    send_word(32'h1234_5678);
    send_byte(8'hAB);
    send_byte(8'hCD);
    rst_n = 1'b0;
    #1;
    vec++; if (rd_valid !== 1'b0) begin miss++; $display("FAIL mid_rd_valid got %0b want 0", rd_valid); end
    vec++; if (sts_valid !== 1'b0) begin miss++; $display("FAIL mid_sts_valid got %0b want 0", sts_valid); end
    vec++; if (err !== 4'h0) begin miss++; $display("FAIL mid_err got %0d want 0", err); end
    vec++; if (arry !== '0) begin miss++; $display("FAIL mid_arry got word0=%h want all zero", aw(0)); end
    c0 = updt_cnt;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_byte(8'hEF);
    send_byte(8'h01);
    send_word(32'h0000_0000);
    repeat (5) @(posedge clk);
    #1;
    vec++; if (updt_cnt !== c0) begin miss++; $display("FAIL mid_no_updt got %0d want %0d", updt_cnt, c0); end
    vec++; if (sts_valid !== 1'b0) begin miss++; $display("FAIL mid_no_sts got %0b want 0", sts_valid); end
    send_hdr(1);
    send_word(32'h0000_0077);
    send_word(32'h0000_0076);
    vec++; if (updt !== 1'b1) begin miss++; $display("FAIL mid_after_updt got %0b want 1", updt); end
    vec++; if (aw(0) !== 32'h0000_0077) begin miss++; $display("FAIL mid_after_arry0 got %h want 00000077", aw(0)); end
    vec++; if (aw(1) !== 32'h0) begin miss++; $display("FAIL mid_after_arry1 got %h want 0", aw(1)); end
  endtask

  initial begin
    test_reset;
    test_good;
    test_xor;
    test_len_err;
    test_timeout;
    test_ovf;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
